// File: rtl/ps2_scancode_decoder_if.sv
// Scan-byte input and decoded-event output bundle for the PS/2 scan code decoder.
// The master side feeds bytes and consumes events. The slave side is the decoder.
interface ps2_scancode_decoder_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    logic [7:0]                  scan_code;
    logic                        scan_valid;
    logic                        evt_ready;
    logic                        evt_valid;
    logic [7:0]                  evt_code;
    logic                        evt_break;
    logic                        evt_ext;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        overflow;
    logic [7:0]                  last_key;

    modport master (
        output scan_code, scan_valid, evt_ready,
        input  evt_valid, evt_code, evt_break, evt_ext, fifo_count, overflow, last_key
    );

    modport slave (
        input  scan_code, scan_valid, evt_ready,
        output evt_valid, evt_code, evt_break, evt_ext, fifo_count, overflow, last_key
    );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan code decoder. It strips E0/F0 prefixes into make/break and extended
// flags, and it queues the decoded key events in a first-word-fall-through FIFO.
module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input logic                   clk,
    input logic                   rst_n,
    ps2_scancode_decoder_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StGotE0, StGotF0, StGotE0F0} state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             emit, emit_break, emit_ext;
    logic             is_e0, is_f0, is_drop;

    logic [9:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic             overflow_q;
    logic [7:0]       last_key_q;

    assign is_e0   = bus.scan_code == 8'hE0;
    assign is_f0   = bus.scan_code == 8'hF0;
    // Keyboard status and ack bytes carry no key information when they arrive unprefixed.
    assign is_drop = bus.scan_code inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hFE};

    // This register holds the decoder state and the prefix idle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // This block computes the prefix decode, the event emit and the timeout of a stale prefix.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        emit       = 1'b0;
        emit_break = 1'b0;
        emit_ext   = 1'b0;
        if (bus.scan_valid) begin
            idle_cnt_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (is_e0)         state_d = StGotE0;
                    else if (is_f0)    state_d = StGotF0;
                    else if (!is_drop) emit = 1'b1;
                end
                StGotE0: begin
                    if (is_f0) state_d = StGotE0F0;
                    else if (!is_e0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StGotF0: begin
                    if (is_e0) state_d = StGotE0F0;
                    else if (!is_f0) begin
                        emit       = 1'b1;
                        emit_break = 1'b1;
                        state_d    = StIdle;
                    end
                end
                StGotE0F0: begin
                    if (!is_e0 && !is_f0) begin
                        emit       = 1'b1;
                        emit_break = 1'b1;
                        emit_ext   = 1'b1;
                        state_d    = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (idle_cnt_q == TMO_LAST) begin
                state_d    = StIdle;
                idle_cnt_d = '0;
            end else begin
                idle_cnt_d = idle_cnt_q + TMO_W'(1);
            end
        end
    end

    // A pop while full frees the slot that the coincident push needs.
    assign pop  = (count_q != '0) && bus.evt_ready;
    assign push = emit && ((count_q != FULL_CNT) || pop);

    // This block computes the next fill level from the push and pop strobes.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // This block writes the event storage. It has no reset because the outputs are gated while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {bus.scan_code, emit_break, emit_ext};
    end

    // This register holds the FIFO pointers, the fill level and the status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_key_q <= 8'h00;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            if (emit && !push)       overflow_q <= 1'b1;
            if (emit && emit_break)  last_key_q <= bus.scan_code;
        end
    end

    assign bus.evt_valid  = count_q != '0;
    assign {bus.evt_code, bus.evt_break, bus.evt_ext} = bus.evt_valid ? mem[rd_ptr_q] : 10'h000;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;
    assign bus.last_key   = last_key_q;
endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of event FIFO entries; a power of two, minimum 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: the number of idle clk cycles after a prefix before the prefix is discarded.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port scan_code  input  8  received PS/2 scan byte from the upstream keyboard receiver.
REQ-006 SHALL have port scan_valid  input  1  one-cycle strobe; scan_code is valid in that cycle.
REQ-007 SHALL have port evt_ready  input  1  consumer accepts the head event.
REQ-008 SHALL have port evt_valid  output  1  FIFO is non-empty; head event is presented.
REQ-009 SHALL have port evt_code  output  8  head event key code (prefixes stripped).
REQ-010 SHALL have port evt_break  output  1  head event: 1 = key release, 0 = key press.
REQ-011 SHALL have port evt_ext  output  1  head event: 1 = E0-extended key.
REQ-012 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored events.
REQ-013 SHALL have port overflow  output  1  sticky flag: an event was dropped because the FIFO was full.
REQ-014 SHALL have port last_key  output  8  code of the most recently decoded break event, for LED display.

Function
REQ-015 SHALL decode with a 4-state FSM: IDLE, GOT_E0, GOT_F0, GOT_E0F0; the FSM advances only in cycles where scan_valid=1.
REQ-016 In IDLE, the decoder SHALL behave as follows:
- E0 -> GOT_E0.
- F0 -> GOT_F0.
- 00, FF, AA, FA, FE -> dropped, stay in IDLE.
- any other code -> emit {code, break=0, ext=0}, stay in IDLE.
REQ-017 In GOT_E0, the decoder SHALL behave as follows:
- F0 -> GOT_E0F0.
- E0 -> stay in GOT_E0.
- any other code -> emit {code, break=0, ext=1}, go to IDLE.
REQ-018 In GOT_F0, the decoder SHALL behave as follows:
- E0 -> GOT_E0F0.
- F0 -> stay in GOT_F0.
- any other code (including AA) -> emit {code, break=1, ext=0}, go to IDLE.
REQ-019 In GOT_E0F0, the decoder SHALL behave as follows:
- E0 or F0 -> stay in GOT_E0F0.
- any other code -> emit {code, break=1, ext=1}, go to IDLE.
REQ-020 An idle counter SHALL clear on every scan_valid; in any non-IDLE state, reaching TIMEOUT_CYCLES cycles without scan_valid SHALL force IDLE with no emit.
REQ-021 An emit SHALL push the FIFO in the same cycle as the scan_valid; the event SHALL be visible on evt_* with evt_valid=1 on the next cycle when the FIFO was empty (latency 1).
REQ-022 The FIFO SHALL be first-word-fall-through; evt_code/evt_break/evt_ext SHALL hold the head entry whenever evt_valid=1 and are don't-care otherwise.
REQ-023 A pop SHALL occur when evt_valid and evt_ready are both 1; evt_ready while empty SHALL have no effect.
REQ-024 On a push while full with no pop: the event SHALL be dropped, overflow SHALL be set, and FIFO contents SHALL be unchanged.
REQ-025 On a simultaneous push and pop while full: both SHALL occur, with no drop and no overflow.
REQ-026 On a simultaneous push and pop while empty: the pop SHALL be ignored, the push SHALL be stored, and fifo_count SHALL become 1.
REQ-027 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH exactly.
REQ-028 last_key SHALL update to the code of every break emit in the cycle of decode, regardless of FIFO acceptance.
REQ-029 overflow SHALL stay set until reset.

Reset
REQ-030 rst_n=0 SHALL immediately force, independent of clk:
- FSM to IDLE and idle counter to 0.
- FIFO empty: evt_valid=0, fifo_count=0.
- overflow=0, last_key=8'h00, evt_code=8'h00, evt_break=0, evt_ext=0.
REQ-031 Reset asserted mid-sequence (e.g. after E0) SHALL discard the pending prefix and all queued events.
REQ-032 After rst_n deasserts, the first scan_valid SHALL be honoured on the first rising clk edge.

Verification
REQ-033 Bytes 1C; F0 1C -> events {1C,0,0} then {1C,1,0}; last_key=1C; fifo_count=2 with evt_ready=0.
REQ-034 Bytes E0 75; E0 F0 75 -> events {75,0,1} then {75,1,1}; bytes AA and FA in IDLE -> no event.
REQ-035 Byte E0, then TIMEOUT_CYCLES idle cycles, then byte 1C -> single event {1C,0,0} (prefix discarded).
REQ-036 Five make codes 15,1D,24,2D,2C with evt_ready=0 -> fifo_count=4, overflow=1; draining yields 15,1D,24,2D.
REQ-037 FIFO full, push coincident with evt_ready=1 -> overflow stays 0, fifo_count stays 4, order preserved.
REQ-038 Bytes E0 F0, then rst_n pulsed low, then byte 74 -> event {74,0,0}; all outputs at reset values during reset.
